// File: rtl/speck_decrypt_core.sv
// Iterative SPECK block decryptor: expands round keys into a local store, then runs rounds in reverse.
// Optional macro SPECK_KEY_CACHE_EN keeps the last expanded key so a repeated key skips expansion.
module speck_decrypt_core #(
    parameter int unsigned WORD_SIZE = 64,
    parameter int unsigned KEY_WORDS = 2,
    parameter int unsigned NR_ROUNDS = 32,
    parameter int unsigned ALPHA     = 8,
    parameter int unsigned BETA      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2*WORD_SIZE-1:0]         ciphertext,
    input  logic [KEY_WORDS*WORD_SIZE-1:0] key,
    output logic                           busy,
    output logic                           finished,
    output logic [2*WORD_SIZE-1:0]         plaintext
);
    localparam int unsigned   CW          = $clog2(NR_ROUNDS);
    localparam int unsigned   LW          = KEY_WORDS - 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(NR_ROUNDS - 1);
    localparam logic [CW-1:0] CNT_EXP_END = CW'(NR_ROUNDS - 2);

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

    function automatic word_t ror_w(input word_t v, input int unsigned s);
        return (v >> s) | (v << (WORD_SIZE - s));
    endfunction

    function automatic word_t rol_w(input word_t v, input int unsigned s);
        return (v << s) | (v >> (WORD_SIZE - s));
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    word_t                  x_q, x_d, y_q, y_d, k_q, k_d;
    word_t                  l_q [LW];
    word_t                  l_d [LW];
    word_t                  rk_q [NR_ROUNDS];
    word_t                  rk_d [NR_ROUNDS];
    logic                   busy_q, busy_d, finished_q, finished_d;
    logic [2*WORD_SIZE-1:0] plaintext_q, plaintext_d;
    word_t                  new_l, k_next, y_dec, x_dec;
`ifdef SPECK_KEY_CACHE_EN
    logic                           cache_valid_q, cache_valid_d;
    logic [KEY_WORDS*WORD_SIZE-1:0] cache_key_q, cache_key_d, key_q, key_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        k_d         = k_q;
        l_d         = l_q;
        rk_d        = rk_q;
        plaintext_d = plaintext_q;
        finished_d  = 1'b0;
`ifdef SPECK_KEY_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_key_d   = cache_key_q;
        key_d         = key_q;
`endif
        new_l  = (k_q + ror_w(l_q[0], ALPHA)) ^ word_t'(cnt_q);
        k_next = rol_w(k_q, BETA) ^ new_l;
        y_dec  = ror_w(x_q ^ y_q, BETA);
        x_dec  = rol_w((x_q ^ rk_q[cnt_q]) - y_dec, ALPHA);

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d      = ciphertext[2*WORD_SIZE-1:WORD_SIZE];
                    y_d      = ciphertext[WORD_SIZE-1:0];
                    k_d      = key[WORD_SIZE-1:0];
                    for (int unsigned j = 0; j < LW; j++) begin
                        l_d[j] = key[(j+1)*WORD_SIZE +: WORD_SIZE];
                    end
                    rk_d[0]  = key[WORD_SIZE-1:0];
                    cnt_d    = '0;
                    state_d  = EXPAND;
`ifdef SPECK_KEY_CACHE_EN
                    key_d = key;
                    if (cache_valid_q && (key == cache_key_q)) begin
                        cnt_d   = CNT_LAST;
                        state_d = DECRYPT;
                    end else begin
                        cache_valid_d = 1'b0;
                    end
`endif
                end
            end
            EXPAND: begin
                // l words form a shift register; the freshly derived word enters at the top
                k_d = k_next;
                for (int unsigned j = 0; j + 1 < LW; j++) begin
                    l_d[j] = l_q[j+1];
                end
                l_d[LW-1]            = new_l;
                rk_d[cnt_q + 1'b1]   = k_next;
                if (cnt_q == CNT_EXP_END) begin
                    cnt_d   = CNT_LAST;
                    state_d = DECRYPT;
`ifdef SPECK_KEY_CACHE_EN
                    cache_valid_d = 1'b1;
                    cache_key_d   = key_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECRYPT: begin
                x_d = x_dec;
                y_d = y_dec;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                plaintext_d = {x_q, y_q};
                finished_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so the DONE cycle shows up one clock later with busy already low.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            plaintext_q <= '0;
`ifdef SPECK_KEY_CACHE_EN
            cache_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            plaintext_q <= plaintext_d;
`ifdef SPECK_KEY_CACHE_EN
            cache_valid_q <= cache_valid_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        x_q  <= x_d;
        y_q  <= y_d;
        k_q  <= k_d;
        l_q  <= l_d;
        rk_q <= rk_d;
`ifdef SPECK_KEY_CACHE_EN
        cache_key_q <= cache_key_d;
        key_q       <= key_d;
`endif
    end

    assign busy      = busy_q;
    assign finished  = finished_q;
    assign plaintext = plaintext_q;

endmodule
